// File: rtl/adder64_wb_pkg.sv
// ============================================================================
// Module      : adder64_wb_pkg
// Description : Shared definitions for the adder64 writeback queue.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package adder64_wb_pkg;

  localparam int LEN_DATA_DEF = 64;

  localparam int NUM_FLAGS = 4;
  localparam int FLAG_N    = 3;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 0;

  typedef struct packed {
    logic a_msb;
    logic b_msb;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/adder64_wb_fifo.sv
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO with occupancy count; read data reads 0 when empty.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int            c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_full);
  assign w_do_pop  = i_pop & ~w_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + c_aw'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + c_aw'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_aw + 1)'(1);
        2'b01:   r_count <= r_count - (c_aw + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/adder64_wb.sv
// ============================================================================
// Module      : adder64_wb
// Description : Pairs adder64 results with issue-time operand MSB tags and
//               queues {sum, flags, zero-byte mask} for a ready/valid consumer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adder64_wb
  import adder64_wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LEN_DATA = LEN_DATA_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   valid,
  input  logic                   a_msb,
  input  logic                   b_msb,
  input  logic [LEN_DATA-1:0]    sum,
  input  logic                   cout,
  input  logic                   rdy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEN_DATA-1:0]    out_sum,
  output logic [NUM_FLAGS-1:0]   out_flags,
  output logic [LEN_DATA/8-1:0]  out_zmask,
  output logic                   err_ovf,
  output logic                   err_unmatched,
  output logic [$clog2(DEPTH):0] count
);

  localparam int                c_zw    = LEN_DATA / 8;
  localparam int                c_res_w = LEN_DATA + NUM_FLAGS + c_zw;
  localparam int                c_cw    = $clog2(DEPTH) + 1;
  localparam logic [c_cw-1:0]   c_full  = c_cw'(DEPTH);

  tag_t                  w_tag_in;
  tag_t                  w_tag_head;
  logic [c_cw-1:0]       w_tag_count;
  logic [c_cw-1:0]       w_res_count;
  logic                  w_tag_empty;
  logic                  w_tag_full;
  logic                  w_res_full;
  logic                  w_tag_push_req;
  logic                  w_tag_pop;
  logic                  w_tag_push_ok;
  logic                  w_res_pop;
  logic                  w_res_push_ok;
  logic                  w_unmatched;
  logic [NUM_FLAGS-1:0]  w_flags;
  logic [c_zw-1:0]       w_zmask;
  logic [c_res_w-1:0]    w_res_wdata;
  logic [c_res_w-1:0]    w_res_rdata;
  logic                  r_err_ovf;
  logic                  r_err_unmatched;

  assign w_tag_in      = '{a_msb: a_msb, b_msb: b_msb};
  assign w_tag_empty   = (w_tag_count == '0);
  assign w_tag_full    = (w_tag_count == c_full);
  assign w_res_full    = (w_res_count == c_full);

  assign w_tag_push_req = en & valid;
  assign w_tag_pop      = en & rdy & ~w_tag_empty;
  assign w_tag_push_ok  = w_tag_push_req & (~w_tag_full | w_tag_pop);
  assign w_res_pop      = out_valid & out_ready;
  // A matched result always consumes its tag, even if the result itself is dropped.
  assign w_res_push_ok  = w_tag_pop & (~w_res_full | w_res_pop);
  assign w_unmatched    = en & rdy & w_tag_empty;

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = sum[LEN_DATA-1];
    w_flags[FLAG_Z] = (sum == '0);
    w_flags[FLAG_C] = cout;
    w_flags[FLAG_V] = (w_tag_head.a_msb == w_tag_head.b_msb) &&
                      (sum[LEN_DATA-1] != w_tag_head.a_msb);
  end

  for (genvar gi = 0; gi < c_zw; gi++) begin : g_zmask
    assign w_zmask[gi] = (sum[gi*8 +: 8] == 8'h00);
  end

  assign w_res_wdata = {sum, w_flags, w_zmask};

  wb_fifo #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_tag_push_ok),
    .i_pop   (w_tag_pop),
    .i_wdata (w_tag_in),
    .o_rdata (w_tag_head),
    .o_count (w_tag_count)
  );

  wb_fifo #(
    .WIDTH (c_res_w),
    .DEPTH (DEPTH)
  ) u_res_q (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_res_push_ok),
    .i_pop   (w_res_pop),
    .i_wdata (w_res_wdata),
    .o_rdata (w_res_rdata),
    .o_count (w_res_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_ovf       <= 1'b0;
      r_err_unmatched <= 1'b0;
    end else begin
      if ((w_tag_push_req & ~w_tag_push_ok) | (w_tag_pop & ~w_res_push_ok)) begin
        r_err_ovf <= 1'b1;
      end
      if (w_unmatched) begin
        r_err_unmatched <= 1'b1;
      end
    end
  end

  assign out_valid     = (w_res_count != '0);
  assign {out_sum, out_flags, out_zmask} = w_res_rdata;
  assign err_ovf       = r_err_ovf;
  assign err_unmatched = r_err_unmatched;
  assign count         = w_res_count;

endmodule

`default_nettype wire

// File: tb/tb_adder64_wb.sv
// ============================================================================
// Module      : tb_adder64_wb
// Description : Directed self-checking bench for adder64_wb.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_adder64_wb;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        valid;
  logic        a_msb;
  logic        b_msb;
  logic [63:0] sum;
  logic        cout;
  logic        rdy;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic [3:0]  out_flags;
  logic [7:0]  out_zmask;
  logic        err_ovf;
  logic        err_unmatched;
  logic [2:0]  count;

  int total;
  int bad;

  logic [63:0] s_tab [5];
  logic [63:0] t_tab [5];

  adder64_wb #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .en            (en),
    .valid         (valid),
    .a_msb         (a_msb),
    .b_msb         (b_msb),
    .sum           (sum),
    .cout          (cout),
    .rdy           (rdy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_flags     (out_flags),
    .out_zmask     (out_zmask),
    .err_ovf       (err_ovf),
    .err_unmatched (err_unmatched),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One issue cycle followed by one result cycle.
  task automatic pair(input logic am, input logic bm, input logic [63:0] s, input logic c);
    valid = 1'b1; a_msb = am; b_msb = bm;
    tick();
    valid = 1'b0;
    rdy = 1'b1; sum = s; cout = c;
    tick();
    rdy = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; en = 1'b0; valid = 1'b0; a_msb = 1'b0; b_msb = 1'b0;
    sum = '0; cout = 1'b0; rdy = 1'b0; out_ready = 1'b0;
    s_tab[0] = 64'h0000_0000_0000_0011;
    s_tab[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    s_tab[2] = 64'h0100_0000_0000_0000;
    s_tab[3] = 64'h0000_0000_0001_0000;
    s_tab[4] = 64'h0000_0000_0000_DEAD;
    t_tab[0] = 64'h1111_0000_0000_0001;
    t_tab[1] = 64'h2222_0000_0000_0002;
    t_tab[2] = 64'h3333_0000_0000_0003;
    t_tab[3] = 64'h4444_0000_0000_0004;
    t_tab[4] = 64'h5555_0000_0000_0005;

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_err_unm", err_unmatched, 0);
    chk("rst_out_sum", out_sum, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Signed overflow: 0x7FFF... + 1
    en = 1'b1;
    valid = 1'b1; a_msb = 1'b0; b_msb = 1'b0;
    tick();
    valid = 1'b0;
    rdy = 1'b1; sum = 64'h8000_0000_0000_0000; cout = 1'b0;
    #1;
    chk("no_bypass_valid", out_valid, 0);
    tick();
    rdy = 1'b0;
    chk("ovf_out_valid", out_valid, 1);
    chk("ovf_count", count, 1);
    chk("ovf_sum", out_sum, 64'h8000_0000_0000_0000);
    chk("ovf_flags", out_flags, 4'b1001);
    chk("ovf_zmask", out_zmask, 8'h7F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_count", count, 0);
    chk("pop_out_valid", out_valid, 0);

    // Zero sum with carry, negative operands
    valid = 1'b1; a_msb = 1'b1; b_msb = 1'b1;
    tick();
    valid = 1'b0;
    rdy = 1'b1; sum = 64'h0; cout = 1'b1; out_ready = 1'b1;
    tick();
    rdy = 1'b0;
    chk("zero_out_valid", out_valid, 1);
    chk("zero_flags", out_flags, 4'b0111);
    chk("zero_zmask", out_zmask, 8'hFF);
    tick();
    out_ready = 1'b0;
    chk("zero_count_after", count, 0);

    // Five pairs into a depth-4 result queue with no consumer
    for (int i = 0; i < 5; i++) pair(1'b0, 1'b0, s_tab[i], 1'b0);
    chk("full_count", count, 4);
    chk("full_err_ovf", err_ovf, 1);
    chk("full_head_flags", out_flags, 4'b0000);
    chk("full_head_zmask", out_zmask, 8'hFE);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_sum%0d", i), out_sum, s_tab[i]);
      if (i == 1) chk("drain_flags1", out_flags, 4'b1001);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);
    chk("err_ovf_sticky", err_ovf, 1);

    // Full queue with simultaneous push and pop
    do_reset();
    chk("rst2_err_ovf", err_ovf, 0);
    for (int i = 0; i < 4; i++) pair(1'b0, 1'b0, t_tab[i], 1'b0);
    chk("sim_pre_count", count, 4);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    rdy = 1'b1; sum = t_tab[4]; out_ready = 1'b1;
    tick();
    rdy = 1'b0; out_ready = 1'b0;
    chk("sim_count", count, 4);
    chk("sim_err_ovf", err_ovf, 0);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("sim_drain%0d", i), out_sum, t_tab[i]);
      tick();
    end
    out_ready = 1'b0;
    chk("sim_drained", count, 0);

    // Capture disabled
    en = 1'b0; valid = 1'b1; rdy = 1'b1;
    tick();
    valid = 1'b0;
    chk("en0_count", count, 0);
    chk("en0_err_unm", err_unmatched, 0);
    chk("en0_err_ovf", err_ovf, 0);

    // Result without a tag
    en = 1'b1;
    tick();
    rdy = 1'b0;
    chk("unm_err", err_unmatched, 1);
    chk("unm_out_valid", out_valid, 0);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) pair(1'b0, 1'b0, s_tab[i], 1'b0);
    chk("mid_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_count", count, 0);
    chk("async_out_sum", out_sum, 0);
    chk("async_flags", out_flags, 0);
    chk("async_zmask", out_zmask, 0);
    chk("async_err_unm", err_unmatched, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Tag queue overflow, starting on the first edge after release
    valid = 1'b1; a_msb = 1'b1; b_msb = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("tagq_no_ovf", err_ovf, 0);
    tick();
    valid = 1'b0;
    chk("tagq_ovf", err_ovf, 1);
    rdy = 1'b1; sum = 64'h0000_0000_0000_0100; cout = 1'b1;
    tick();
    rdy = 1'b0;
    chk("tagq_count", count, 1);
    chk("tagq_flags", out_flags, 4'b0010);
    chk("tagq_zmask", out_zmask, 8'hFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
